// File: rtl/actmem_write_controller_pkg.sv
// Shared CUTIE definitions: activation-memory geometry helpers and the
// write-controller state enum.
package actmem_write_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_e;

   function automatic int eff_trits(input int n_i, input int ws);
      return n_i / ws;
   endfunction

   function automatic int phys_bits(input int n_i, input int ws);
      return ((n_i / ws + 4) / 5) * 8;
   endfunction

   function automatic int num_banks(input int k, input int ws);
      return k * ws;
   endfunction

   // Trits per bank first, then words per bank, both rounded up.
   function automatic int bank_depth(input int cells, input int banks,
                                     input int eff);
      int per_bank;
      per_bank = (cells + banks - 1) / banks;
      return (per_bank + eff - 1) / eff;
   endfunction

   function automatic int clog2_min1(input int v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/actmem_write_controller.sv
// Streams encoded activation words into the banked activation memory,
// packing them linearly across banks with registered write ports.
module actmem_write_controller
   import actmem_write_controller_pkg::*;
#(
   parameter int N_I            = 512,
   parameter int K              = 3,
   parameter int WEIGHT_STAGGER = 8,
   parameter int IMAGEWIDTH     = 224,
   parameter int IMAGEHEIGHT    = 224,
   localparam int EFFECTIVETRITSPERWORD = eff_trits(N_I, WEIGHT_STAGGER),
   localparam int PHYSICALBITSPERWORD   = phys_bits(N_I, WEIGHT_STAGGER),
   localparam int NUMBANKS              = num_banks(K, WEIGHT_STAGGER),
   localparam int BANKDEPTH = bank_depth(IMAGEWIDTH * IMAGEHEIGHT * N_I,
                                         NUMBANKS, EFFECTIVETRITSPERWORD),
   localparam int AW  = clog2_min1(BANKDEPTH),
   localparam int WW  = $clog2(IMAGEWIDTH + 1),
   localparam int HW  = $clog2(IMAGEHEIGHT + 1),
   localparam int WPW = $clog2(WEIGHT_STAGGER + 1),
   localparam int PW  = PHYSICALBITSPERWORD
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         start_i,
   input  logic [WW-1:0]                width_i,
   input  logic [HW-1:0]                height_i,
   input  logic [WPW-1:0]               words_per_pixel_i,
   input  logic                         valid_i,
   input  logic [PW-1:0]                wdata_i,
   output logic                         ready_o,
   output logic [0:NUMBANKS-1]          write_enable_o,
   output logic [0:NUMBANKS-1][AW-1:0]  addr_o,
   output logic [0:NUMBANKS-1][PW-1:0]  wdata_o,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         err_o
);

   localparam int BW  = clog2_min1(NUMBANKS);
   localparam int PXW = WW + HW;

   state_e                       r_state;
   logic [WW-1:0]                r_w;
   logic [HW-1:0]                r_h;
   logic [WPW-1:0]               r_wpp;
   logic [BW-1:0]                r_bank;
   logic [AW-1:0]                r_addr;
   logic [WPW-1:0]               r_word;
   logic [PXW-1:0]               r_pix;
   logic [0:NUMBANKS-1]          r_we;
   logic [0:NUMBANKS-1][AW-1:0]  r_addr_o;
   logic [0:NUMBANKS-1][PW-1:0]  r_wd_o;
   logic                         r_done;
   logic                         r_err;

   logic                         w_legal;
   logic [PXW-1:0]               w_npix;
   logic                         w_word_wrap;
   logic                         w_last;

   assign w_legal = (width_i != '0) && (height_i != '0) &&
                    (words_per_pixel_i != '0) &&
                    (words_per_pixel_i <= WPW'(WEIGHT_STAGGER));

   assign w_npix      = PXW'(r_w) * PXW'(r_h);
   assign w_word_wrap = (r_word == r_wpp - WPW'(1));
   assign w_last      = w_word_wrap && (r_pix == w_npix - PXW'(1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= ST_IDLE;
         r_w      <= '0;
         r_h      <= '0;
         r_wpp    <= '0;
         r_bank   <= '0;
         r_addr   <= '0;
         r_word   <= '0;
         r_pix    <= '0;
         r_we     <= '0;
         r_addr_o <= '0;
         r_wd_o   <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_we     <= '0;
         r_addr_o <= '0;
         r_wd_o   <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (start_i) begin
                  if (w_legal) begin
                     r_w     <= width_i;
                     r_h     <= height_i;
                     r_wpp   <= words_per_pixel_i;
                     r_bank  <= '0;
                     r_addr  <= '0;
                     r_word  <= '0;
                     r_pix   <= '0;
                     r_state <= ST_RUN;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (valid_i) begin
                  r_we[r_bank]     <= 1'b1;
                  r_addr_o[r_bank] <= r_addr;
                  r_wd_o[r_bank]   <= wdata_i;
                  if (r_bank == BW'(NUMBANKS - 1)) begin
                     r_bank <= '0;
                     r_addr <= r_addr + AW'(1);
                  end else begin
                     r_bank <= r_bank + BW'(1);
                  end
                  if (w_word_wrap) begin
                     r_word <= '0;
                     r_pix  <= r_pix + PXW'(1);
                  end else begin
                     r_word <= r_word + WPW'(1);
                  end
                  if (w_last) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ready_o        = (r_state == ST_RUN);
   assign busy_o         = (r_state != ST_IDLE);
   assign done_o         = r_done;
   assign err_o          = r_err;
   assign write_enable_o = r_we;
   assign addr_o         = r_addr_o;
   assign wdata_o        = r_wd_o;

endmodule

// File: doc/actmem_write_controller.md
ACTMEM_WRITE_CONTROLLER -- requirements
Module: actmem_write_controller

Interface
REQ-001 SHALL have parameter N_I, default 512: maximum input channels per pixel.
REQ-002 SHALL have parameter K, default 3: kernel size; sets the bank count.
REQ-003 SHALL have parameter WEIGHT_STAGGER, default 8: maximum encoded words per pixel.
REQ-004 SHALL have parameters IMAGEWIDTH, default 224, and IMAGEHEIGHT, default 224: maximum image dimensions.
REQ-005 SHALL derive localparams from the shared package:
- EFFECTIVETRITSPERWORD = N_I/WEIGHT_STAGGER
- PHYSICALBITSPERWORD = ceil(EFFECTIVETRITSPERWORD/5)*8
- NUMBANKS = K*WEIGHT_STAGGER
- BANKDEPTH = ceil(ceil(IMAGEWIDTH*IMAGEHEIGHT*N_I/NUMBANKS)/EFFECTIVETRITSPERWORD)
REQ-006 SHALL have ports, one per line (name, direction, width, meaning):
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  single-cycle pulse that launches an image load.
- width_i  in  clog2(IMAGEWIDTH+1)  pixels per row.
- height_i  in  clog2(IMAGEHEIGHT+1)  rows.
- words_per_pixel_i  in  clog2(WEIGHT_STAGGER+1)  encoded words per pixel.
- valid_i  in  1  upstream word valid.
- wdata_i  in  PHYSICALBITSPERWORD  encoded activation word.
- ready_o  out  1  controller accepts a word.
- write_enable_o  out  [0:NUMBANKS-1]  per-bank write strobe.
- addr_o  out  [0:NUMBANKS-1][clog2(BANKDEPTH)]  per-bank address.
- wdata_o  out  [0:NUMBANKS-1][PHYSICALBITSPERWORD]  per-bank write data.
- busy_o  out  1  load in progress.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle illegal-configuration pulse.

Function
REQ-007 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-008 In IDLE, start_i with legal configuration SHALL do all of the following:
- latch width, height and words-per-pixel;
- clear the bank pointer, address register and word/pixel counters;
- enter RUN.
REQ-009 A configuration is legal iff width_i>=1, height_i>=1 and 1<=words_per_pixel_i<=WEIGHT_STAGGER.
REQ-010 An illegal start SHALL pulse err_o for one cycle and SHALL remain in IDLE.
REQ-011 ready_o SHALL equal (state==RUN); busy_o SHALL equal (state!=IDLE).
REQ-012 A word SHALL transfer only in a cycle with valid_i && ready_o.
REQ-013 Each transferred word SHALL be written exactly one cycle later with registered outputs:
- write_enable_o one-hot at the current bank pointer;
- that bank's addr_o set to the address register;
- wdata_o[bank] set to wdata_i.
REQ-014 Non-selected banks SHALL see write_enable 0, address 0 and data 0; write_enable_o SHALL be all-zero in cycles without a transfer.
REQ-015 Words SHALL pack linearly with no per-pixel padding: global word g maps to bank g mod NUMBANKS and address g div NUMBANKS.
REQ-016 The bank pointer SHALL wrap from NUMBANKS-1 to 0, and the address register SHALL increment on that wrap.
REQ-017 The word-in-pixel counter SHALL wrap at words_per_pixel-1, incrementing the pixel counter on wrap.
REQ-018 The pixel counter SHALL cover width*height pixels.
REQ-019 The transfer of the last word (last pixel, last word) SHALL move the FSM to DONE.
REQ-020 In DONE, ready_o SHALL be 0, done_o SHALL be 1 for exactly that cycle (same cycle as the final write strobe), and the FSM SHALL return to IDLE.
REQ-021 start_i SHALL be ignored in RUN and DONE; no err_o is raised.
REQ-022 valid_i outside RUN SHALL be ignored.
REQ-023 Upstream stalls (valid_i low) SHALL hold all counters.

Reset
REQ-024 rst_i SHALL have priority over every other input.
REQ-025 On the cycle after rst_i is asserted, all of the following SHALL hold:
- FSM in IDLE;
- all counters cleared;
- ready_o, busy_o, done_o and err_o are 0;
- write_enable_o, addr_o and wdata_o are all-zero.
REQ-026 Reset asserted mid-RUN SHALL abort the load; a write registered for that cycle SHALL NOT be issued.

Structure
REQ-027 The derived widths (EFFECTIVETRITSPERWORD, PHYSICALBITSPERWORD, NUMBANKS, BANKDEPTH) and the FSM state enum SHALL live in the shared CUTIE package, common with the activation memory.
REQ-028 The block SHALL have no sub-modules; the bank-pointer/address counter pair is inline.

Verification
Bench parameters: N_I=16, K=3, WEIGHT_STAGGER=2, IMAGEWIDTH=4, IMAGEHEIGHT=4. This gives NUMBANKS=6, PHYSICALBITSPERWORD=16 and BANKDEPTH=6.
REQ-029 Scenario 1: start with 2x2, 2 words/pixel, valid held high, data 0x00..0x07.
- Words 0..5 -> banks 0..5 at addr 0.
- Word 6 -> bank 0 addr 1; word 7 -> bank 1 addr 1.
- done_o high in the cycle of the word-7 strobe.
REQ-030 Scenario 2: start with 4x4, 1 word/pixel, 16 words.
- Word 12 -> bank 0 addr 2; word 15 -> bank 3 addr 2.
- Exactly 16 strobes are issued.
REQ-031 Scenario 3: repeat scenario 1 with valid_i toggling every cycle.
- No strobe follows a valid-low cycle.
- Final mapping is identical; done_o arrives 7 cycles later than in scenario 1.
REQ-032 Scenario 4: start with words_per_pixel_i=3.
- err_o pulses once; FSM stays IDLE.
- ready_o and busy_o stay 0; no strobes are issued.
REQ-033 Scenario 5: assert rst_i after 3 transfers of scenario 1.
- Next cycle all outputs are 0 and no word-3 strobe is issued.
- A fresh start writes its first word to bank 0 addr 0.
REQ-034 Scenario 6: pulse start_i in the 4th RUN cycle with a different config.
- The pulse is ignored.
- The load completes with the original 8-word mapping; err_o stays 0.
